service_2_countdown: RTL
========================

SERVICE_2_COUNTDOWN -- requirements
Module: service_2_countdown

Interface
REQ-001 Parameter TICK_DIV, default 100000000, SHALL set the number of clk cycles per 1-second count tick.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset (reset=0 resets immediately, regardless of clk).
REQ-004 finish1  input  1  SHALL be the time-set-complete flag from the upstream time-set stage; it is level-high once setting ends.
REQ-005 time_in  input  16  SHALL be the BCD time MM:SS from the time-set stage: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones; each digit is 0-9.
REQ-006 spdt2  input  1  SHALL be the run switch: 1 = run, 0 = pause.
REQ-007 push_c  input  1  SHALL be the one-cycle acknowledge/clear pulse.
REQ-008 num  output  16  SHALL be the remaining time in the same BCD layout as time_in.
REQ-009 sel  output  4  SHALL be the per-digit display enable, with bit 3 as the leftmost digit.
REQ-010 finish2  output  1  SHALL be high while the countdown has expired and is not yet acknowledged.

Function
REQ-011 The FSM SHALL have states IDLE, LOADED, RUN, PAUSE and DONE.
REQ-012 In IDLE, the block SHALL transition to LOADED and copy time_in into num on the first cycle in which finish1=1 (level-sensitive).
REQ-013 In LOADED, the block SHALL transition to RUN when spdt2=1 and SHALL clear the prescaler on that transition.
REQ-014 In RUN, the prescaler SHALL count 0..TICK_DIV-1; in the cycle it equals TICK_DIV-1 it SHALL wrap to 0 and decrement num by one second.
REQ-015 In RUN with spdt2=0, the block SHALL go to PAUSE, holding num and prescaler; in PAUSE with spdt2=1, it SHALL return to RUN and resume from the held prescaler value.
REQ-016 BCD decrement: sec ones>0 SHALL give ones-1; otherwise ones SHALL become 9 and sec tens decrements.
REQ-017 If sec tens and sec ones are both 0, seconds SHALL become 59 and minutes SHALL decrement with the same ones/tens borrow rule.
REQ-018 Seconds-tens values 6-9 from upstream SHALL be counted down as-is (e.g. 00:90 lasts 90 ticks) and SHALL NOT be clamped.
REQ-019 When a decrement yields 0000, the block SHALL enter DONE in the same cycle num becomes 0000.
REQ-020 In RUN with num=0000 (loaded zero), the block SHALL enter DONE on the next edge without waiting for a tick.
REQ-021 In DONE, finish2 SHALL be 1, num SHALL hold 0000, and sel SHALL toggle between 4'b1111 and 4'b0000 on every prescaler wrap.
REQ-022 In DONE, the prescaler SHALL free-run regardless of spdt2.
REQ-023 In DONE, push_c=1 SHALL return the block to IDLE with num=0, sel=0 and finish2=0.
REQ-024 In IDLE, sel SHALL be 4'b0000; in LOADED, RUN and PAUSE, sel SHALL be 4'b1111.
REQ-025 push_c SHALL be ignored in every state except DONE and PAUSE.
REQ-026 In PAUSE, push_c=1 SHALL abort to IDLE with num=0.
REQ-027 If the tick wrap and spdt2 falling edge coincide in RUN, the decrement SHALL be applied and the block SHALL then enter PAUSE.
REQ-028 After returning to IDLE, the block SHALL reload only while finish1=1; if finish1 stays high, LOADED SHALL be re-entered on the next cycle with the current time_in.

Reset
REQ-029 reset=0 SHALL force state IDLE, num=0, sel=0, finish2=0 and prescaler=0 asynchronously, including mid-RUN or mid-DONE.
REQ-030 After reset release, the block SHALL act on inputs from the first rising clk edge.

Verification
REQ-031 Scenario (TICK_DIV=4): time_in=0x0102, finish1=1, then spdt2=1 -> num reads 0101, 0100, 0059, 0058 at 4-cycle intervals.
REQ-032 Scenario: time_in=0x1000 counted down -> the single tick yields 0959.
REQ-033 Scenario: time_in=0x0002, run -> DONE after 2 ticks with finish2=1 and sel alternating 1111/0000 every 4 cycles; then push_c -> IDLE with num=0, sel=0, finish2=0.
REQ-034 Scenario: spdt2 dropped 2 cycles into a tick and raised 10 cycles later -> next decrement occurs 2 cycles after resume; num is unchanged during PAUSE.
REQ-035 Scenario: time_in=0x0000, run -> DONE one cycle after entering RUN with finish2=1.
REQ-036 Scenario: reset=0 asserted between clk edges mid-RUN -> all outputs are 0 immediately, and they stay 0 until finish1 is seen after release.

Source files
------------

// File: rtl/service_2_countdown_if.sv
// service_2_countdown_if
//   Groups the time-set handshake, run/ack controls and display outputs of the
//   countdown stage into one bundle.
//   Signals:
//     finish1  - time-set complete flag from the upstream stage (level)
//     time_in  - BCD MM:SS to load {min tens, min ones, sec tens, sec ones}
//     spdt2    - run switch, 1 = run, 0 = pause
//     push_c   - one-cycle acknowledge / clear pulse
//     num      - remaining time, same BCD layout as time_in
//     sel      - per-digit display enable, bit 3 = leftmost digit
//     finish2  - countdown expired and not yet acknowledged
//   Modports: master drives the inputs and observes the outputs; slave is the
//   countdown block itself.
interface service_2_countdown_if;
    logic        finish1;
    logic [15:0] time_in;
    logic        spdt2;
    logic        push_c;
    logic [15:0] num;
    logic [3:0]  sel;
    logic        finish2;

    modport master (
        output finish1, time_in, spdt2, push_c,
        input  num, sel, finish2
    );

    modport slave (
        input  finish1, time_in, spdt2, push_c,
        output num, sel, finish2
    );
endinterface

// File: rtl/service_2_countdown.sv
// service_2_countdown
//   MM:SS BCD countdown timer. Loads the time from the time-set stage, counts
//   it down one second per TICK_DIV clocks while the run switch is on, and
//   flashes the display once the count reaches zero until acknowledged.
//   Parameters:
//     TICK_DIV - clk cycles per one-second tick
//   Ports:
//     clk      - single clock, rising edge
//     reset    - asynchronous active-low reset
//     bus      - slave side of service_2_countdown_if (controls + display)
module service_2_countdown #(
    parameter int TICK_DIV = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    service_2_countdown_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state, state_nx;
    logic [15:0]    num_q, num_nx;
    logic [3:0]     sel_q, sel_nx;
    logic           fin_q, fin_nx;
    logic [PW-1:0]  presc, presc_nx;
    logic [15:0]    num_dec;
    logic           tick;

    // One-second BCD decrement. Seconds tens above 5 are not clamped: they
    // simply borrow digit-wise like any other value. Borrowing out of 00
    // seconds reloads 59 and borrows from the minutes.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            so = 4'd9;
            st = st - 4'd1;
        end else begin
            so = 4'd9;
            st = 4'd5;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mo = 4'd9;
                mt = mt - 4'd1;
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign num_dec = bcd_dec(num_q);
    assign tick    = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            num_q <= 16'h0000;
            sel_q <= 4'b0000;
            fin_q <= 1'b0;
            presc <= '0;
        end else begin
            state <= state_nx;
            num_q <= num_nx;
            sel_q <= sel_nx;
            fin_q <= fin_nx;
            presc <= presc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        num_nx   = num_q;
        sel_nx   = sel_q;
        fin_nx   = fin_q;
        presc_nx = presc;

        case (state)
            IDLE: begin
                sel_nx = 4'b0000;
                fin_nx = 1'b0;
                // Level-sensitive: a still-high finish1 reloads immediately.
                if (bus.finish1) begin
                    state_nx = LOADED;
                    num_nx   = bus.time_in;
                    sel_nx   = 4'b1111;
                end
            end

            LOADED: begin
                if (bus.spdt2) begin
                    state_nx = RUN;
                    presc_nx = '0;
                end
            end

            RUN: begin
                if (num_q == 16'h0000) begin
                    // Loaded zero: expire without waiting for a tick.
                    state_nx = DONE;
                    fin_nx   = 1'b1;
                    presc_nx = '0;
                end else if (tick) begin
                    // A tick that coincides with the switch going off still
                    // takes effect before pausing.
                    presc_nx = '0;
                    num_nx   = num_dec;
                    if (num_dec == 16'h0000) begin
                        state_nx = DONE;
                        fin_nx   = 1'b1;
                    end else if (!bus.spdt2) begin
                        state_nx = PAUSE;
                    end
                end else if (bus.spdt2) begin
                    presc_nx = presc + PW'(1);
                end else begin
                    state_nx = PAUSE;
                end
            end

            PAUSE: begin
                if (bus.push_c) begin
                    state_nx = IDLE;
                    num_nx   = 16'h0000;
                    sel_nx   = 4'b0000;
                end else if (bus.spdt2) begin
                    state_nx = RUN;
                end
            end

            DONE: begin
                if (bus.push_c) begin
                    state_nx = IDLE;
                    num_nx   = 16'h0000;
                    sel_nx   = 4'b0000;
                    fin_nx   = 1'b0;
                    presc_nx = '0;
                end else if (tick) begin
                    // Prescaler free-runs here to pace the display flash.
                    presc_nx = '0;
                    sel_nx   = ~sel_q;
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.num     = num_q;
    assign bus.sel     = sel_q;
    assign bus.finish2 = fin_q;

endmodule
